rtr_next_hop_lar_pipe: RTL and testbench

//  Multi-channel, pipelined lookahead-routing unit for the phased-DOR router.
//  Per channel, for each head flit leaving on lar_info's port/class, it computes the next router's address
//  and the lar_info the next router will use (next port + resource class, incl. phase switch).

---
 rtl/rtr_next_hop_lar_pipe_pkg.sv | 14 +
 rtl/rtr_lar_route_calc.sv | 65 ++++++
 rtl/rtr_next_hop_lar_pipe.sv | 140 ++++++++++++++
 tb/tb_rtr_next_hop_lar_pipe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rtr_next_hop_lar_pipe_pkg.sv
// rtr_next_hop_lar_pipe_pkg: topology/routing constants and width helpers for the lookahead routing pipe
package rtr_next_hop_lar_pipe_pkg;
  typedef enum logic [1:0] {CONNECTIVITY_LINE, CONNECTIVITY_RING, CONNECTIVITY_FULL} connectivity_e;
  typedef enum logic [0:0] {ROUTING_TYPE_PHASED_DOR} routing_type_e;
  function automatic int clogb(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int nbrs_per_dim(input connectivity_e conn, input int n);
    return conn == CONNECTIVITY_FULL ? n - 1 : 2;
  endfunction
endpackage

// File: rtl/rtr_lar_route_calc.sv
// rtr_lar_route_calc: combinational phased-DOR route (port, class) a router at cur_addr applies to a header
module rtr_lar_route_calc
  import rtr_next_hop_lar_pipe_pkg::*;
#(
  parameter int num_resource_classes = 2,
  parameter int num_routers_per_dim = 4,
  parameter int num_dimensions = 2,
  parameter int num_nodes_per_router = 1,
  parameter connectivity_e connectivity = CONNECTIVITY_LINE,
  localparam int dim_addr_width = clogb(num_routers_per_dim),
  localparam int router_addr_width = num_dimensions * dim_addr_width,
  localparam int node_addr_width = clogb(num_nodes_per_router),
  localparam int rc_idx_width = clogb(num_resource_classes),
  localparam int num_neighbors_per_dim = nbrs_per_dim(connectivity, num_routers_per_dim),
  localparam int num_ports = num_dimensions * num_neighbors_per_dim + num_nodes_per_router,
  localparam int port_idx_width = clogb(num_ports),
  localparam int dest_info_width = num_resource_classes * router_addr_width + node_addr_width
) (
  input  logic [router_addr_width-1:0] cur_addr,
  input  logic [dest_info_width-1:0]   dest_info,
  input  logic [rc_idx_width-1:0]      rc,
  output logic [port_idx_width-1:0]    port,
  output logic [rc_idx_width-1:0]      next_rc
);
  localparam int n = num_routers_per_dim;
  localparam int eject_base = num_dimensions * num_neighbors_per_dim;
  logic [router_addr_width-1:0] dest;
  logic [port_idx_width-1:0] dim_port, eject_port;
  int ld, cd, dd;
  // Class advances while this router already is the current phase's destination.
  always_comb begin
    next_rc = rc;
    for (int k = 0; k < num_resource_classes - 1; k++)
      if (next_rc == rc_idx_width'(k) &&
          cur_addr == dest_info[node_addr_width + k*router_addr_width +: router_addr_width])
        next_rc = rc_idx_width'(k + 1);
    dest = dest_info[node_addr_width + int'(next_rc)*router_addr_width +: router_addr_width];
    ld = 0;
    cd = 0;
    dd = 0;
    for (int d = num_dimensions - 1; d >= 0; d--)
      if (cur_addr[d*dim_addr_width +: dim_addr_width] != dest[d*dim_addr_width +: dim_addr_width]) begin
        ld = d;
        cd = int'(cur_addr[d*dim_addr_width +: dim_addr_width]);
        dd = int'(dest[d*dim_addr_width +: dim_addr_width]);
      end
  end
  case (connectivity)
    CONNECTIVITY_RING: begin : g_ring
      assign dim_port = port_idx_width'(2*ld + ((((dd - cd + n) % n) <= n/2) ? 1 : 0));
    end
    CONNECTIVITY_FULL: begin : g_full
      assign dim_port = port_idx_width'(ld*(n-1) + (dd - cd - 1 + 2*n) % n);
    end
    default: begin : g_line
      assign dim_port = port_idx_width'(2*ld + (dd > cd ? 1 : 0));
    end
  endcase
  if (node_addr_width > 0) begin : g_node
    assign eject_port = port_idx_width'(eject_base + int'(dest_info[node_addr_width-1:0]));
  end else begin : g_one
    assign eject_port = port_idx_width'(eject_base);
  end
  assign port = cur_addr == dest ? eject_port : dim_port;
endmodule

// File: rtl/rtr_next_hop_lar_pipe.sv
// rtr_next_hop_lar_pipe: per-channel two-stage pipe computing next-hop address and the next router's lar_info
module rtr_next_hop_lar_pipe
  import rtr_next_hop_lar_pipe_pkg::*;
#(
  parameter int num_channels = 2,
  parameter int num_resource_classes = 2,
  parameter int num_routers_per_dim = 4,
  parameter int num_dimensions = 2,
  parameter int num_nodes_per_router = 1,
  parameter connectivity_e connectivity = CONNECTIVITY_LINE,
  parameter routing_type_e routing_type = ROUTING_TYPE_PHASED_DOR,
  localparam int dim_addr_width = clogb(num_routers_per_dim),
  localparam int router_addr_width = num_dimensions * dim_addr_width,
  localparam int node_addr_width = clogb(num_nodes_per_router),
  localparam int rc_idx_width = clogb(num_resource_classes),
  localparam int num_neighbors_per_dim = nbrs_per_dim(connectivity, num_routers_per_dim),
  localparam int num_ports = num_dimensions * num_neighbors_per_dim + num_nodes_per_router,
  localparam int port_idx_width = clogb(num_ports),
  localparam int dest_info_width = num_resource_classes * router_addr_width + node_addr_width,
  localparam int lar_info_width = port_idx_width + rc_idx_width
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [router_addr_width-1:0]               router_address,
  input  logic [num_channels-1:0]                    in_valid,
  output logic [num_channels-1:0]                    in_ready,
  input  logic [num_channels*dest_info_width-1:0]    in_dest_info,
  input  logic [num_channels*lar_info_width-1:0]     in_lar_info,
  output logic [num_channels-1:0]                    out_valid,
  input  logic [num_channels-1:0]                    out_ready,
  output logic [num_channels*router_addr_width-1:0]  out_next_addr,
  output logic [num_channels*lar_info_width-1:0]     out_lar_info,
  output logic [num_channels*dest_info_width-1:0]    out_dest_info,
  output logic [num_channels-1:0]                    err_route
);
  localparam int n = num_routers_per_dim;
  localparam int daw = dim_addr_width;
  // Any hop under an unsupported routing scheme is flagged as illegal.
  localparam bit dor_ok = routing_type == ROUTING_TYPE_PHASED_DOR;
  for (genvar c = 0; c < num_channels; c++) begin : g_ch
    logic [dest_info_width-1:0] di, s1_di, s2_di;
    logic [port_idx_width-1:0] port, calc_port;
    logic [rc_idx_width-1:0] rc, s1_rc, calc_rc;
    logic [router_addr_width-1:0] next_addr, s1_addr, s2_addr;
    logic [lar_info_width-1:0] s2_lar;
    logic hop_err, s1_valid, s2_valid, err, s2_load;
    assign di = in_dest_info[c*dest_info_width +: dest_info_width];
    assign {port, rc} = in_lar_info[c*lar_info_width +: lar_info_width];
    assign s2_load = !s2_valid || out_ready[c];
    assign in_ready[c] = !s1_valid || s2_load;
    case (connectivity)
      CONNECTIVITY_RING: begin : g_ring
        always_comb begin
          next_addr = router_address;
          hop_err = !dor_ok;
          for (int d = 0; d < num_dimensions; d++) begin
            if (port == port_idx_width'(2*d))
              next_addr[d*daw +: daw] = router_address[d*daw +: daw] == '0 ?
                daw'(n-1) : router_address[d*daw +: daw] - daw'(1);
            if (port == port_idx_width'(2*d+1))
              next_addr[d*daw +: daw] = router_address[d*daw +: daw] == daw'(n-1) ?
                '0 : router_address[d*daw +: daw] + daw'(1);
          end
        end
      end
      CONNECTIVITY_FULL: begin : g_full
        logic [router_addr_width-1:0] dest;
        assign dest = di[node_addr_width + int'(rc)*router_addr_width +: router_addr_width];
        always_comb begin
          next_addr = router_address;
          hop_err = !dor_ok;
          for (int d = 0; d < num_dimensions; d++)
            if (int'(port) >= d*(n-1) && int'(port) < (d+1)*(n-1))
              next_addr[d*daw +: daw] = dest[d*daw +: daw];
        end
      end
      default: begin : g_line
        always_comb begin
          next_addr = router_address;
          hop_err = !dor_ok;
          for (int d = 0; d < num_dimensions; d++) begin
            if (port == port_idx_width'(2*d)) begin
              if (router_address[d*daw +: daw] == '0) hop_err = 1'b1;
              else next_addr[d*daw +: daw] = router_address[d*daw +: daw] - daw'(1);
            end
            if (port == port_idx_width'(2*d+1)) begin
              if (router_address[d*daw +: daw] == daw'(n-1)) hop_err = 1'b1;
              else next_addr[d*daw +: daw] = router_address[d*daw +: daw] + daw'(1);
            end
          end
        end
      end
    endcase
    rtr_lar_route_calc #(
      .num_resource_classes(num_resource_classes),
      .num_routers_per_dim(num_routers_per_dim),
      .num_dimensions(num_dimensions),
      .num_nodes_per_router(num_nodes_per_router),
      .connectivity(connectivity)
    ) u_calc (
      .cur_addr(s1_addr),
      .dest_info(s1_di),
      .rc(s1_rc),
      .port(calc_port),
      .next_rc(calc_rc)
    );
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        err <= 1'b0;
        s1_addr <= '0;
        s1_rc <= '0;
        s1_di <= '0;
        s2_addr <= '0;
        s2_lar <= '0;
        s2_di <= '0;
      end else begin
        if (in_ready[c]) s1_valid <= in_valid[c];
        if (in_ready[c] && in_valid[c]) begin
          s1_addr <= next_addr;
          s1_rc <= rc;
          s1_di <= di;
          err <= err | hop_err;
        end
        if (s2_load) s2_valid <= s1_valid;
        if (s2_load && s1_valid) begin
          s2_addr <= s1_addr;
          s2_lar <= {calc_port, calc_rc};
          s2_di <= s1_di;
        end
      end
    end
    assign out_valid[c] = s2_valid;
    assign err_route[c] = err;
    assign out_next_addr[c*router_addr_width +: router_addr_width] = s2_addr;
    assign out_lar_info[c*lar_info_width +: lar_info_width] = s2_lar;
    assign out_dest_info[c*dest_info_width +: dest_info_width] = s2_di;
  end
endmodule

// File: tb/tb_rtr_next_hop_lar_pipe.sv
// tb_rtr_next_hop_lar_pipe: directed checks of a LINE and a RING 4x4 instance
module tb_rtr_next_hop_lar_pipe;
  import rtr_next_hop_lar_pipe_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] rtr, rtr_r;
  logic [1:0] iv, ir, ov, ordy, err, iv_r, ir_r, ov_r, ordy_r, err_r;
  logic [15:0] di, di_r, odi, odi_r;
  logic [7:0] li, li_r, oli, oli_r, ona, ona_r;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rtr_next_hop_lar_pipe dut (
    .clk(clk), .reset(reset), .router_address(rtr),
    .in_valid(iv), .in_ready(ir), .in_dest_info(di), .in_lar_info(li),
    .out_valid(ov), .out_ready(ordy), .out_next_addr(ona), .out_lar_info(oli),
    .out_dest_info(odi), .err_route(err)
  );
  rtr_next_hop_lar_pipe #(.connectivity(CONNECTIVITY_RING)) dut_r (
    .clk(clk), .reset(reset), .router_address(rtr_r),
    .in_valid(iv_r), .in_ready(ir_r), .in_dest_info(di_r), .in_lar_info(li_r),
    .out_valid(ov_r), .out_ready(ordy_r), .out_next_addr(ona_r), .out_lar_info(oli_r),
    .out_dest_info(odi_r), .err_route(err_r)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input bit ring, input logic [3:0] ra, input logic [7:0] d,
                         input logic [3:0] l, input logic [3:0] ea, input logic [3:0] el,
                         input string tag);
    if (ring) begin
      rtr_r = ra; di_r[7:0] = d; li_r[3:0] = l; iv_r[0] = 1'b1;
    end else begin
      rtr = ra; di[7:0] = d; li[3:0] = l; iv[0] = 1'b1;
    end
    tick;
    iv[0] = 1'b0;
    iv_r[0] = 1'b0;
    chk({tag, "_lat1"}, 32'(ring ? ov_r[0] : ov[0]), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(ring ? ov_r[0] : ov[0]), 32'd1);
    chk({tag, "_addr"}, 32'(ring ? ona_r[3:0] : ona[3:0]), 32'(ea));
    chk({tag, "_lar"}, 32'(ring ? oli_r[3:0] : oli[3:0]), 32'(el));
    chk({tag, "_dest"}, 32'(ring ? odi_r[7:0] : odi[7:0]), 32'(d));
    tick;
    chk({tag, "_drain"}, 32'(ring ? ov_r[0] : ov[0]), 32'd0);
  endtask
  initial begin
    rtr = '0; rtr_r = '0; iv = '0; iv_r = '0; di = '0; di_r = '0; li = '0; li_r = '0;
    ordy = 2'b11; ordy_r = 2'b11;
    #2;
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(ona), 32'd0);
    tick;
    tick;
    reset = 1'b1;
    chk("rst_ready", 32'(ir), 32'd3);
    // addresses packed {dim1, dim0}; dest_info {orc1, orc0}; lar {port, rc}
    run_one(1'b0, 4'h9, 8'h3A, 4'h2, 4'hA, 4'h3, "line_phase");
    run_one(1'b0, 4'h9, 8'hF1, 4'h6, 4'hD, 4'h4, "line_dim1");
    run_one(1'b0, 4'h2, 8'h35, 4'h3, 4'h3, 4'h9, "eject");
    run_one(1'b1, 4'h0, 8'h66, 4'h0, 4'h3, 4'h0, "ring_wrap");
    run_one(1'b1, 4'hF, 8'h11, 4'h6, 4'h3, 4'h2, "ring_tie");
    rtr = 4'h9; ordy[0] = 1'b0; di[7:0] = 8'h3A; li[3:0] = 4'h2; iv[0] = 1'b1;
    tick;
    chk("bp_ready1", 32'(ir[0]), 32'd1);
    di[7:0] = 8'h44;
    tick;
    chk("bp_full", 32'(ir[0]), 32'd0);
    chk("bp_ov", 32'(ov[0]), 32'd1);
    chk("bp_h1", 32'(odi[7:0]), 32'h3A);
    di[7:0] = 8'hFF;
    tick;
    chk("bp_full2", 32'(ir[0]), 32'd0);
    chk("bp_hold_dest", 32'(odi[7:0]), 32'h3A);
    chk("bp_hold_addr", 32'(ona[3:0]), 32'hA);
    chk("bp_hold_lar", 32'(oli[3:0]), 32'h3);
    ordy[0] = 1'b1;
    tick;
    iv[0] = 1'b0;
    chk("bp_h2_valid", 32'(ov[0]), 32'd1);
    chk("bp_h2_dest", 32'(odi[7:0]), 32'h44);
    chk("bp_h2_lar", 32'(oli[3:0]), 32'h0);
    tick;
    chk("bp_h3_dest", 32'(odi[7:0]), 32'hFF);
    chk("bp_h3_lar", 32'(oli[3:0]), 32'h2);
    tick;
    chk("bp_empty", 32'(ov[0]), 32'd0);
    rtr = 4'h3; di[15:8] = 8'h00; li[7:4] = 4'h2; iv[1] = 1'b1;
    tick;
    iv[1] = 1'b0;
    chk("err_set", 32'(err), 32'd2);
    tick;
    chk("err_ov", 32'(ov), 32'd2);
    chk("err_addr", 32'(ona[7:4]), 32'h3);
    chk("err_lar", 32'(oli[7:4]), 32'h0);
    repeat (3) tick;
    chk("err_sticky", 32'(err), 32'd2);
    rtr = 4'h9; ordy = 2'b00; di[7:0] = 8'h3A; li[3:0] = 4'h2; iv[0] = 1'b1;
    tick;
    tick;
    chk("mid_ov", 32'(ov[0]), 32'd1);
    chk("mid_full", 32'(ir[0]), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(ov), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    iv = 2'b00;
    ordy = 2'b11;
    tick;
    reset = 1'b1;
    repeat (3) tick;
    chk("post_rst_ov", 32'(ov), 32'd0);
    chk("post_rst_ready", 32'(ir), 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
